// File: rtl/nonce_dispatch_if.sv
// Host/core signal bundle for the nonce dispatcher.
// master drives the host and core strobes; slave is the dispatcher itself.
interface nonce_dispatch_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned CIDX_W    = 2
);
  logic                      start_stop;
  logic                      host_break;
  logic                      wr_start_nonce;
  logic [31:0]               start_nonce;
  logic [NUM_CORES-1:0]      wr_nonce;
  logic [NUM_CORES-1:0]      ticket2moon;
  logic [32*NUM_CORES-1:0]   core_nonce;
  logic                      go_success;
  logic                      go_unsuccess;
  logic [31:0]               gold_nonce;
  logic [CIDX_W-1:0]         gold_core;
  logic [47:0]               hashes_done;
  logic                      running;

  modport master (
    output start_stop, host_break, wr_start_nonce, start_nonce, wr_nonce, ticket2moon,
    input  core_nonce, go_success, go_unsuccess, gold_nonce, gold_core, hashes_done, running
  );

  modport slave (
    input  start_stop, host_break, wr_start_nonce, start_nonce, wr_nonce, ticket2moon,
    output core_nonce, go_success, go_unsuccess, gold_nonce, gold_core, hashes_done, running
  );
endinterface

// File: rtl/nonce_dispatch.sv
// Hands out interleaved nonces to NUM_CORES hashing threads and reports the
// winning nonce or exhaustion of the 32-bit nonce space.
module nonce_dispatch #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned NONCE_LAG = 1,
  parameter int unsigned CIDX_W    = 2
) (
  input  logic            clk_h,
  input  logic            rst_n,
  nonce_dispatch_if.slave bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StArmed   = 3'd1;
  localparam logic [2:0] StRun     = 3'd2;
  localparam logic [2:0] StWin     = 3'd3;
  localparam logic [2:0] StExhaust = 3'd4;

  localparam logic [31:0] Step   = 32'(NUM_CORES);
  localparam logic [31:0] Limit  = 32'hFFFF_FFFF - Step;
  localparam logic [31:0] LagOff = 32'(NONCE_LAG * NUM_CORES);

  logic [2:0]               state_q, state_d;
  logic [32*NUM_CORES-1:0]  nonce_q, nonce_d;
  logic [NUM_CORES-1:0]     done_q, done_d;
  logic [47:0]              hashes_q, hashes_d;
  logic [31:0]              gold_nonce_q, gold_nonce_d;
  logic [CIDX_W-1:0]        gold_core_q, gold_core_d;
  logic                     go_success_q, go_unsuccess_q, running_q;

  logic                     load;
  logic                     found;
  logic [31:0]              swapped;
  logic [31:0]              cur;
  logic [7:0]               adv_cnt;
  logic [48:0]              hash_sum;

  assign swapped = {bus.start_nonce[7:0], bus.start_nonce[15:8],
                    bus.start_nonce[23:16], bus.start_nonce[31:24]};

  always_comb begin
    state_d      = state_q;
    nonce_d      = nonce_q;
    done_d       = done_q;
    hashes_d     = hashes_q;
    gold_nonce_d = gold_nonce_q;
    gold_core_d  = gold_core_q;
    load         = 1'b0;
    found        = 1'b0;
    cur          = '0;
    adv_cnt      = '0;
    hash_sum     = '0;

    case (state_q)
      StIdle: begin
        if (bus.wr_start_nonce && !bus.host_break) begin
          load    = 1'b1;
          state_d = StArmed;
        end
      end
      StArmed: begin
        load    = bus.wr_start_nonce && !bus.host_break;
        state_d = (bus.host_break || !bus.start_stop) ? StIdle : StRun;
      end
      StRun: begin
        if (bus.host_break || !bus.start_stop) begin
          state_d = StIdle;
        end else begin
          // A core whose next step would pass 0xFFFFFFFF parks and stops counting.
          for (int i = 0; i < int'(NUM_CORES); i++) begin
            cur = nonce_q[32*i +: 32];
            if (bus.wr_nonce[i] && !done_q[i]) begin
              if (cur > Limit) begin
                done_d[i] = 1'b1;
              end else begin
                nonce_d[32*i +: 32] = cur + Step;
                adv_cnt             = adv_cnt + 8'd1;
              end
            end
          end
          hash_sum = {1'b0, hashes_q} + 49'(adv_cnt);
          hashes_d = hash_sum[48] ? '1 : hash_sum[47:0];

          for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (bus.ticket2moon[i] && !found) begin
              found        = 1'b1;
              gold_core_d  = CIDX_W'(i);
              gold_nonce_d = nonce_q[32*i +: 32] - LagOff;
            end
          end

          if (found)        state_d = StWin;
          else if (&done_d) state_d = StExhaust;
        end
      end
      StWin, StExhaust: state_d = StIdle;
      default:          state_d = StIdle;
    endcase

    if (load) begin
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        nonce_d[32*i +: 32] = swapped + 32'(i);
      end
      done_d       = '0;
      hashes_d     = '0;
      gold_nonce_d = '0;
      gold_core_d  = '0;
    end
  end

  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      nonce_q        <= '0;
      done_q         <= '0;
      hashes_q       <= '0;
      gold_nonce_q   <= '0;
      gold_core_q    <= '0;
      go_success_q   <= 1'b0;
      go_unsuccess_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      nonce_q        <= nonce_d;
      done_q         <= done_d;
      hashes_q       <= hashes_d;
      gold_nonce_q   <= gold_nonce_d;
      gold_core_q    <= gold_core_d;
      go_success_q   <= (state_d == StWin);
      go_unsuccess_q <= (state_d == StExhaust);
      running_q      <= (state_d == StRun);
    end
  end

  assign bus.core_nonce   = nonce_q;
  assign bus.go_success   = go_success_q;
  assign bus.go_unsuccess = go_unsuccess_q;
  assign bus.gold_nonce   = gold_nonce_q;
  assign bus.gold_core    = gold_core_q;
  assign bus.hashes_done  = hashes_q;
  assign bus.running      = running_q;

endmodule

// File: tb/tb_nonce_dispatch.sv
// Directed bench for nonce_dispatch with NUM_CORES=4, NONCE_LAG=1.
module tb_nonce_dispatch;

  logic clk_h = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  nonce_dispatch_if #(.NUM_CORES(4), .CIDX_W(2)) bus ();

  nonce_dispatch #(.NUM_CORES(4), .NONCE_LAG(1), .CIDX_W(2)) dut (
    .clk_h (clk_h),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_h = ~clk_h;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic pulses(input string tag, input logic s, input logic u);
    chk({tag, "_succ"}, 128'(bus.go_success), 128'(s));
    chk({tag, "_unsucc"}, 128'(bus.go_unsuccess), 128'(u));
  endtask

  // Load a host word and advance ARMED -> RUN.
  task automatic load_and_run(input logic [31:0] word);
    bus.start_stop     = 1'b1;
    bus.start_nonce    = word;
    bus.wr_start_nonce = 1'b1;
    tick();
    bus.wr_start_nonce = 1'b0;
    tick();
  endtask

  initial begin
    bus.start_stop     = 1'b0;
    bus.host_break     = 1'b0;
    bus.wr_start_nonce = 1'b0;
    bus.start_nonce    = '0;
    bus.wr_nonce       = '0;
    bus.ticket2moon    = '0;
    #12;
    chk("rst_nonce", 128'(bus.core_nonce), 128'h0);
    chk("rst_hashes", 128'(bus.hashes_done), 128'h0);
    chk("rst_gold", 128'({bus.gold_nonce, bus.gold_core}), 128'h0);
    chk("rst_flags", 128'({bus.go_success, bus.go_unsuccess, bus.running}), 128'h0);
    rst_n = 1'b1;

    // Load and byte-swap.
    bus.start_stop     = 1'b1;
    bus.start_nonce    = 32'h0016_ADCC;
    bus.wr_start_nonce = 1'b1;
    tick();
    bus.wr_start_nonce = 1'b0;
    chk("load_nonce", 128'(bus.core_nonce), 128'hCCAD1603_CCAD1602_CCAD1601_CCAD1600);
    chk("armed_not_running", 128'(bus.running), 128'h0);
    tick();
    chk("run_running", 128'(bus.running), 128'h1);

    // Three strobes on core 2, then tickets on cores 1 and 2.
    bus.wr_nonce = 4'b0100;
    repeat (3) tick();
    bus.wr_nonce = 4'b0000;
    chk("adv_nonce", 128'(bus.core_nonce), 128'hCCAD1603_CCAD160E_CCAD1601_CCAD1600);
    chk("adv_hashes", 128'(bus.hashes_done), 128'd3);
    pulses("pre_win", 1'b0, 1'b0);
    bus.ticket2moon = 4'b0110;
    tick();
    bus.ticket2moon = 4'b0000;
    pulses("win", 1'b1, 1'b0);
    chk("win_core", 128'(bus.gold_core), 128'd1);
    chk("win_gold", 128'(bus.gold_nonce), 128'hCCAD15FD);
    chk("win_not_running", 128'(bus.running), 128'h0);
    tick();
    pulses("win_after", 1'b0, 1'b0);
    chk("win_gold_held", 128'(bus.gold_nonce), 128'hCCAD15FD);

    // Exhaustion: every core parks on its first strobe.
    load_and_run(32'hFCFF_FFFF);
    chk("ex_load", 128'(bus.core_nonce), 128'hFFFFFFFF_FFFFFFFE_FFFFFFFD_FFFFFFFC);
    bus.wr_nonce = 4'b1111;
    tick();
    bus.wr_nonce = 4'b0000;
    pulses("exhaust", 1'b0, 1'b1);
    chk("ex_nonce", 128'(bus.core_nonce), 128'hFFFFFFFF_FFFFFFFE_FFFFFFFD_FFFFFFFC);
    chk("ex_hashes", 128'(bus.hashes_done), 128'd0);
    tick();
    pulses("ex_after", 1'b0, 1'b0);

    // Ticket in the same cycle the last core parks: success wins.
    load_and_run(32'hFCFF_FFFF);
    bus.wr_nonce    = 4'b1111;
    bus.ticket2moon = 4'b1001;
    tick();
    bus.wr_nonce    = 4'b0000;
    bus.ticket2moon = 4'b0000;
    pulses("tie", 1'b1, 1'b0);
    chk("tie_core", 128'(bus.gold_core), 128'd0);
    chk("tie_gold", 128'(bus.gold_nonce), 128'hFFFFFFF8);
    tick();
    pulses("tie_after", 1'b0, 1'b0);

    // Partial exhaustion: one core parks while others still advance.
    load_and_run(32'hF8FF_FFFF);
    bus.wr_nonce = 4'b1111;
    tick();
    chk("part_adv", 128'(bus.core_nonce), 128'hFFFFFFFF_FFFFFFFE_FFFFFFFD_FFFFFFFC);
    chk("part_hashes4", 128'(bus.hashes_done), 128'd4);
    bus.wr_nonce = 4'b0001;
    tick();
    chk("part_one_done", 128'({bus.running, bus.go_unsuccess}), 128'b10);
    chk("part_hashes_held", 128'(bus.hashes_done), 128'd4);
    bus.wr_nonce = 4'b1110;
    tick();
    bus.wr_nonce = 4'b0000;
    pulses("part_exhaust", 1'b0, 1'b1);
    tick();

    // Host break mid-RUN, then break beating a load.
    load_and_run(32'h0016_ADCC);
    bus.wr_nonce = 4'b0001;
    tick();
    chk("brk_adv", 128'(bus.core_nonce), 128'hCCAD1603_CCAD1602_CCAD1601_CCAD1604);
    bus.host_break = 1'b1;
    bus.wr_nonce   = 4'b0010;
    tick();
    pulses("brk", 1'b0, 1'b0);
    chk("brk_running", 128'(bus.running), 128'h0);
    chk("brk_nonce", 128'(bus.core_nonce), 128'hCCAD1603_CCAD1602_CCAD1601_CCAD1604);
    chk("brk_hashes", 128'(bus.hashes_done), 128'd1);
    bus.host_break = 1'b0;
    tick();
    chk("idle_strobe", 128'(bus.core_nonce), 128'hCCAD1603_CCAD1602_CCAD1601_CCAD1604);
    bus.wr_nonce       = 4'b0000;
    bus.host_break     = 1'b1;
    bus.wr_start_nonce = 1'b1;
    bus.start_nonce    = 32'h0000_0000;
    tick();
    bus.host_break     = 1'b0;
    bus.wr_start_nonce = 1'b0;
    tick();
    chk("brk_blocks_load", 128'(bus.core_nonce), 128'hCCAD1603_CCAD1602_CCAD1601_CCAD1604);
    chk("brk_blocks_run", 128'(bus.running), 128'h0);

    // start_stop low in RUN stops without a pulse.
    load_and_run(32'h0100_0000);
    bus.start_stop = 1'b0;
    tick();
    chk("stop_running", 128'(bus.running), 128'h0);
    pulses("stop", 1'b0, 1'b0);
    chk("stop_nonce", 128'(bus.core_nonce), 128'h00000004_00000003_00000002_00000001);

    // Asynchronous reset mid-RUN.
    load_and_run(32'h0016_ADCC);
    bus.wr_nonce = 4'b1000;
    tick();
    bus.wr_nonce = 4'b0000;
    chk("pre_rst_hashes", 128'(bus.hashes_done), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_nonce", 128'(bus.core_nonce), 128'h0);
    chk("arst_hashes", 128'(bus.hashes_done), 128'h0);
    chk("arst_flags", 128'({bus.go_success, bus.go_unsuccess, bus.running}), 128'h0);
    tick();
    rst_n = 1'b1;
    bus.ticket2moon = 4'b1111;
    tick();
    tick();
    bus.ticket2moon = 4'b0000;
    pulses("post_rst_ticket", 1'b0, 1'b0);
    chk("post_rst_gold", 128'({bus.gold_nonce, bus.gold_core}), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nonce_dispatch.md
NONCE_DISPATCH -- requirements
Module: nonce_dispatch

Interface
REQ-001 Parameter NUM_CORES, default 4: number of hashing threads; legal 1, 2, 4, 8.
REQ-002 Parameter NONCE_LAG, default 1: wr_nonce strobes between a nonce's issue and its ticket2moon.
REQ-003 Parameter CIDX_W, default 2: core index width, equal to max(1, log2(NUM_CORES)).
REQ-004 clk_h  in  1  hash clock; all logic is synchronous to its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start_stop  in  1  1 = mining enabled, 0 = stop.
REQ-007 host_break  in  1  abort request from the host link.
REQ-008 wr_start_nonce  in  1  one-cycle strobe that loads start_nonce.
REQ-009 start_nonce  in  32  host word, byte-swapped on load (bytes [7:0],[15:8],[23:16],[31:24] become [31:24]..[7:0]).
REQ-010 wr_nonce  in  NUM_CORES  per-core advance strobe, driven by each core's m1 sequencer.
REQ-011 ticket2moon  in  NUM_CORES  per-core target-hit flag.
REQ-012 core_nonce  out  32*NUM_CORES  current nonce per core; core i occupies bits [32i+31:32i].
REQ-013 go_success  out  1  one-cycle pulse: a winning nonce was found.
REQ-014 go_unsuccess  out  1  one-cycle pulse: the nonce space is exhausted.
REQ-015 gold_nonce  out  32  winning nonce; held until the next load.
REQ-016 gold_core  out  CIDX_W  index of the winning core.
REQ-017 hashes_done  out  48  count of wr_nonce strobes accepted since the last load.
REQ-018 running  out  1  high while in the RUN state.

Function
REQ-019 The FSM SHALL have the states IDLE, ARMED, RUN, WIN and EXHAUST.
- IDLE -> ARMED on wr_start_nonce.
- ARMED -> RUN when start_stop=1 and host_break=0.
- RUN -> WIN on any ticket2moon bit.
- RUN -> EXHAUST when every core is done.
- WIN and EXHAUST -> IDLE after exactly one cycle.
REQ-020 On a load, core i SHALL take the value swapped(start_nonce)+i mod 2^32; hashes_done SHALL clear and the per-core done flags SHALL clear.
REQ-021 A load in ARMED SHALL reload all values; a load in RUN, WIN or EXHAUST SHALL be ignored.
REQ-022 In RUN, a wr_nonce[i] strobe SHALL advance core i by NUM_CORES, unless core i is done.
- Core i becomes done when its advance would exceed 0xFFFFFFFF; in that case the nonce holds and does not wrap.
REQ-023 Strobes received outside RUN SHALL be ignored, both for the nonce and for hashes_done.
REQ-024 hashes_done SHALL add popcount(wr_nonce & ~done) each RUN cycle and SHALL saturate at 2^48-1.
REQ-025 On a ticket in RUN, the lowest set index i SHALL win.
- gold_core = i.
- gold_nonce = core_nonce[i] - NONCE_LAG*NUM_CORES mod 2^32, captured in the same cycle as the ticket.
REQ-026 go_success SHALL be high only during the WIN state; go_unsuccess SHALL be high only during the EXHAUST state.
REQ-027 If a ticket and the last done flag occur in the same cycle, the FSM SHALL enter WIN (success has priority).
REQ-028 host_break=1 or start_stop=0 in ARMED or RUN SHALL force IDLE with no pulse; nonces and hashes_done SHALL hold their values.
REQ-029 host_break SHALL take priority over wr_start_nonce in the same cycle, so no load occurs.
REQ-030 Pulse outputs SHALL be registered and free of glitches.
- Decision-to-pulse latency is 1 cycle (ticket in cycle N gives go_success in cycle N+1).

Reset
REQ-031 With rst_n=0, the block SHALL asynchronously enter IDLE and set every output to 0: core_nonce, gold_nonce, gold_core, hashes_done, go_success, go_unsuccess and running.
REQ-032 Reset SHALL take effect from any state, including mid-RUN; the first active edge after deassertion SHALL see IDLE.

Verification
REQ-033 Load start_nonce=0x0016ADCC with NUM_CORES=4 -> core_nonce = 0xCCAD1600, 0xCCAD1601, 0xCCAD1602, 0xCCAD1603.
REQ-034 Run, strobe core 2 three times, then ticket2moon=0b0110 -> go_success one cycle later; gold_core=1; gold_nonce=0xCCAD1601-4=0xCCAD15FD.
REQ-035 Load 0xFCFFFFFF (swapped 0xFFFFFFFC), run, one strobe per core -> all cores done, nonces unchanged; go_unsuccess for one cycle; hashes_done=0.
REQ-036 In the same exhaustion setup, assert a ticket in the cycle the last core becomes done -> go_success only, with no go_unsuccess.
REQ-037 Mid-RUN host_break -> IDLE, no pulse, nonces held; a subsequent strobe does not change core_nonce.
REQ-038 Drop rst_n mid-RUN -> all outputs 0 immediately, before any clock edge; after release, ticket2moon is ignored until a load and run.
